// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial-data and status bundle for the pattern-detect controller.
// master = bit source / sequencer side, slave = seq_detect_ctrl.
interface seq_detect_ctrl_if #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic [CNT_W-1:0] cfg_target;
   logic             start;
   logic             stop;
   logic             x_valid;
   logic             x;
   logic             z;
   logic [CNT_W-1:0] match_cnt;
   logic             busy;
   logic             done;

   modport master (
      output cfg_valid, cfg_pattern, cfg_len, cfg_target, start, stop, x_valid, x,
      input  cfg_ready, z, match_cnt, busy, done
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_len, cfg_target, start, stop, x_valid, x,
      output cfg_ready, z, match_cnt, busy, done
   );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: overlapping matches on a gated bit stream,
// per-match z pulse, saturating match counter and target-reached DONE state.
module seq_detect_ctrl #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   seq_detect_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [PAT_W-1:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic [PAT_W-1:0] r_pat;
   logic [LEN_W-1:0] r_len;
   logic [CNT_W-1:0] r_tgt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_z;
   logic             r_busy;
   logic             r_done;
   logic             r_cfg_ready;

   logic [PAT_W-1:0] w_hist_nxt;
   logic [LEN_W-1:0] w_fill_nxt;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W-1:0] w_len_clamp;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_match;
   logic             w_cfg_hs;

   assign w_hist_nxt = {r_hist[PAT_W-2:0], bus.x};
   assign w_fill_nxt = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
   assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
   assign w_cfg_hs   = bus.cfg_valid & r_cfg_ready;

   // Out-of-range lengths are folded into 1..PAT_W at capture time.
   always_comb begin
      w_len_clamp = bus.cfg_len;
      if (bus.cfg_len == '0)
         w_len_clamp = LEN_W'(1);
      else if (bus.cfg_len > LEN_W'(PAT_W))
         w_len_clamp = LEN_W'(PAT_W);
   end

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++)
         w_mask[i] = (i < int'(r_len));
   end

   assign w_match = bus.x_valid & (w_fill_nxt >= r_len) &
                    (((w_hist_nxt ^ r_pat) & w_mask) == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_hist      <= '0;
         r_fill      <= '0;
         r_pat       <= '0;
         r_len       <= LEN_W'(PAT_W);
         r_tgt       <= '0;
         r_cnt       <= '0;
         r_z         <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_ready <= 1'b1;
      end else begin
         r_z <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_cfg_hs) begin
                  r_pat <= bus.cfg_pattern;
                  r_len <= w_len_clamp;
                  r_tgt <= bus.cfg_target;
               end
               if (bus.start) begin
                  r_state     <= S_RUN;
                  r_hist      <= '0;
                  r_fill      <= '0;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_cfg_ready <= 1'b0;
               end
            end
            S_RUN: begin
               if (bus.x_valid) begin
                  r_hist <= w_hist_nxt;
                  r_fill <= w_fill_nxt;
               end
               if (w_match) begin
                  r_z   <= 1'b1;
                  r_cnt <= w_cnt_nxt;
               end
               // stop wins over reaching the target on the same edge
               if (bus.stop) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_cfg_ready <= 1'b1;
               end else if (w_match && r_tgt != '0 && w_cnt_nxt == r_tgt) begin
                  r_state     <= S_DONE;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_cfg_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
               r_cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cfg_ready = r_cfg_ready;
   assign bus.z         = r_z;
   assign bus.match_cnt = r_cnt;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed-vector bench for seq_detect_ctrl; expected values are hand-derived.
module tb_seq_detect_ctrl;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   seq_detect_ctrl_if #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) bus ();

   seq_detect_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive at negedge, then sample 1 time unit after the following posedge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_start(input logic [7:0] pat, input logic [3:0] len,
                            input logic [7:0] tgt, input logic st);
      @(negedge clk);
      bus.cfg_valid   = 1'b1;
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_target  = tgt;
      bus.start       = st;
      step();
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.start     = 1'b0;
   endtask

   task automatic send(input logic b, input logic v, input logic sp);
      @(negedge clk);
      bus.x       = b;
      bus.x_valid = v;
      bus.stop    = sp;
      step();
      @(negedge clk);
      bus.x_valid = 1'b0;
      bus.stop    = 1'b0;
   endtask

   logic [9:0] stream;
   logic [9:0] zexp;

   initial begin
      total = 0;
      bad   = 0;
      bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0;
      bus.start = 0; bus.stop = 0; bus.x_valid = 0; bus.x = 0;
      reset = 1'b1;
      step(); step();
      @(negedge clk) reset = 1'b0;

      // reset values; after reset pattern=0, len=8, target=0
      chk("rst_ready", {31'd0, bus.cfg_ready}, 1);
      chk("rst_busy",  {31'd0, bus.busy}, 0);
      chk("rst_cnt",   {24'd0, bus.match_cnt}, 0);
      cfg_start(8'h00, 4'd8, 8'd0, 1'b0);   // cfg only, no start: len 8 zeros
      cfg_start(8'h00, 4'd0, 8'd0, 1'b1);   // start with len 0 -> clamps to 1
      chk("start_busy",  {31'd0, bus.busy}, 1);
      chk("start_ready", {31'd0, bus.cfg_ready}, 0);
      send(1'b0, 1'b1, 1'b0);
      chk("pre_rst_z", {31'd0, bus.z}, 1);
      send(1'b0, 1'b1, 1'b0);
      chk("pre_rst_cnt", {24'd0, bus.match_cnt}, 2);

      // reset held 2 cycles mid-RUN
      @(negedge clk) reset = 1'b1;
      step(); step();
      chk("mid_rst_z",     {31'd0, bus.z}, 0);
      chk("mid_rst_cnt",   {24'd0, bus.match_cnt}, 0);
      chk("mid_rst_busy",  {31'd0, bus.busy}, 0);
      chk("mid_rst_ready", {31'd0, bus.cfg_ready}, 1);
      @(negedge clk) reset = 1'b0;

      // reset config: pattern 0, len 8 -> first z on the 8th zero
      @(negedge clk) bus.start = 1'b1;
      step();
      @(negedge clk) bus.start = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         send(1'b0, 1'b1, 1'b0);
         chk($sformatf("rstcfg_z%0d", i), {31'd0, bus.z}, (i >= 8) ? 1 : 0);
      end
      send(1'b0, 1'b0, 1'b1);
      chk("rstcfg_stop_busy", {31'd0, bus.busy}, 0);

      // overlap: 0110, target 0
      stream = 10'b0110110110;   // bit9 sent first
      zexp   = 10'b0001001001;
      cfg_start(8'h06, 4'd4, 8'd0, 1'b1);
      for (int i = 9; i >= 0; i--) begin
         send(stream[i], 1'b1, 1'b0);
         chk($sformatf("ovl_z%0d", 10 - i), {31'd0, bus.z}, {31'd0, zexp[i]});
      end
      chk("ovl_cnt", {24'd0, bus.match_cnt}, 3);
      send(1'b0, 1'b0, 1'b1);

      // done after 2nd match
      cfg_start(8'h06, 4'd4, 8'd2, 1'b1);
      chk("done_cnt_clr", {24'd0, bus.match_cnt}, 0);
      for (int i = 9; i >= 3; i--) send(stream[i], 1'b1, 1'b0);
      chk("done_done",  {31'd0, bus.done}, 1);
      chk("done_busy",  {31'd0, bus.busy}, 0);
      chk("done_ready", {31'd0, bus.cfg_ready}, 1);
      for (int i = 2; i >= 0; i--) begin
         send(stream[i], 1'b1, 1'b0);
         chk("done_noz", {31'd0, bus.z}, 0);
      end
      chk("done_cnt", {24'd0, bus.match_cnt}, 2);

      // gating and fill: 111, x_valid every 3rd cycle
      cfg_start(8'h07, 4'd3, 8'd0, 1'b1);
      chk("gate_done_drop", {31'd0, bus.done}, 0);
      for (int k = 1; k <= 4; k++) begin
         send(1'b1, 1'b0, 1'b0);
         chk("gate_idle_z", {31'd0, bus.z}, 0);
         send(1'b1, 1'b0, 1'b0);
         send(1'b1, 1'b1, 1'b0);
         chk($sformatf("gate_z%0d", k), {31'd0, bus.z}, (k >= 3) ? 1 : 0);
      end
      chk("gate_cnt", {24'd0, bus.match_cnt}, 2);

      // cfg in RUN ignored
      @(negedge clk);
      bus.cfg_valid = 1'b1; bus.cfg_pattern = 8'h00; bus.cfg_len = 4'd1; bus.cfg_target = 8'd1;
      step();
      chk("run_cfg_ready", {31'd0, bus.cfg_ready}, 0);
      @(negedge clk) bus.cfg_valid = 1'b0;
      send(1'b1, 1'b1, 1'b0);
      chk("run_cfg_z", {31'd0, bus.z}, 1);
      chk("run_cfg_busy", {31'd0, bus.busy}, 1);
      send(1'b0, 1'b0, 1'b1);
      chk("stop_hold_cnt", {24'd0, bus.match_cnt}, 3);
      chk("stop_busy", {31'd0, bus.busy}, 0);

      // single-bit run to DONE, then cfg+start in DONE
      cfg_start(8'h01, 4'd1, 8'd1, 1'b1);
      send(1'b1, 1'b1, 1'b0);
      chk("one_done", {31'd0, bus.done}, 1);
      chk("one_cnt", {24'd0, bus.match_cnt}, 1);
      cfg_start(8'h00, 4'd0, 8'd0, 1'b1);
      chk("done_hs_cnt",  {24'd0, bus.match_cnt}, 0);
      chk("done_hs_busy", {31'd0, bus.busy}, 1);
      send(1'b0, 1'b1, 1'b0);
      chk("clamp_z0", {31'd0, bus.z}, 1);
      send(1'b1, 1'b1, 1'b0);
      chk("clamp_z1", {31'd0, bus.z}, 0);

      // stop coincident with match
      send(1'b0, 1'b1, 1'b1);
      chk("stopm_z",     {31'd0, bus.z}, 1);
      chk("stopm_cnt",   {24'd0, bus.match_cnt}, 2);
      chk("stopm_busy",  {31'd0, bus.busy}, 0);
      chk("stopm_ready", {31'd0, bus.cfg_ready}, 1);
      send(1'b0, 1'b1, 1'b0);
      chk("idle_noz", {31'd0, bus.z}, 0);
      chk("idle_cnt", {24'd0, bus.match_cnt}, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
